// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte (e.g. 0xED set LEDs, 0xF4 enable, 0xFF reset) to the
// attached keyboard/mouse. The open-drain CLK/DAT lines are driven through
// active-high pull-low enables. Each accepted byte ends with exactly one
// tx_done pulse (ACK received) or one tx_error pulse (timeout or missing ACK).
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   tx_data     command byte, sampled only when accepted
//   tx_valid    request to send tx_data
//   tx_ready    high only in IDLE; accept = tx_valid & tx_ready
//   tx_done     one-cycle pulse: byte sent and ACK seen
//   tx_error    one-cycle pulse: timeout or missing ACK
//   busy        high whenever not IDLE; the receive path ignores the bus then
//   ps2_clk_in  raw CLK line level
//   ps2_dat_in  raw DAT line level
//   ps2_clk_oe  1 = pull CLK low
//   ps2_dat_oe  1 = pull DAT low
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for tx_valid, lines released
// S_INHIBIT | host holds CLK low for N_INH cycles
// S_RTS     | DAT low (start bit), CLK released, waiting for first device fall
// S_DATA    | each fall presents the next data bit, LSB first
// S_PARITY  | parity bit on the line, next fall releases DAT (stop bit)
// S_STOP    | stop bit on the line, next fall samples the device ACK
// S_RELEASE | ACK seen, waiting for both lines to return high
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ      = 50000000,
    parameter int INHIBIT_US       = 100,
    parameter int START_TIMEOUT_US = 15000,
    parameter int BIT_TIMEOUT_US   = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int          CYC_PER_US = CLK_FREQ_HZ / 1000000;
    localparam logic [23:0] N_INH      = 24'(CYC_PER_US * INHIBIT_US);
    localparam logic [23:0] N_START    = 24'(CYC_PER_US * START_TIMEOUT_US);
    localparam logic [23:0] N_BIT      = 24'(CYC_PER_US * BIT_TIMEOUT_US);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic        parity_q, parity_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [23:0] timer_q, timer_d;
    logic        clk_oe_d, dat_oe_d;
    logic        done_d, error_d;
    logic        error_go;

    // [0] = metastability stage, [1] = synchronised level
    logic [1:0]  clk_sync_q, dat_sync_q;
    logic        clk_prev_q;
    logic        fall_q;

    logic        clk_line, dat_line;
    logic        bit_tc;

    assign clk_line = clk_sync_q[1];
    assign dat_line = dat_sync_q[1];
    assign bit_tc   = (timer_q == N_BIT - 24'd1);

    // Synchronisers reset to the idle-high line level so that leaving reset
    // can never look like a device clock fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
            clk_prev_q <= clk_line;
            fall_q     <= clk_prev_q & ~clk_line;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            parity_q   <= 1'b0;
            bitcnt_q   <= '0;
            timer_q    <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            bitcnt_q   <= bitcnt_d;
            timer_q    <= timer_d;
            ps2_clk_oe <= clk_oe_d;
            ps2_dat_oe <= dat_oe_d;
            tx_done    <= done_d;
            tx_error   <= error_d;
            tx_ready   <= (state_d == S_IDLE);
            busy       <= (state_d != S_IDLE);
        end
    end

    // In every state that waits on the device, a fall takes priority over a
    // timer terminal count landing in the same cycle.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        parity_d = parity_q;
        bitcnt_d = bitcnt_q;
        timer_d  = timer_q + 24'd1;
        clk_oe_d = ps2_clk_oe;
        dat_oe_d = ps2_dat_oe;
        done_d   = 1'b0;
        error_d  = 1'b0;
        error_go = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (tx_valid && tx_ready) begin
                    data_d   = tx_data;
                    parity_d = ~^tx_data;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end

            // Falls seen here are our own CLK pull-down and are ignored.
            S_INHIBIT: begin
                if (timer_q == N_INH - 24'd1) begin
                    dat_oe_d = 1'b1;
                    clk_oe_d = 1'b0;
                    timer_d  = '0;
                    state_d  = S_RTS;
                end
            end

            S_RTS: begin
                if (fall_q) begin
                    dat_oe_d = ~data_q[0];
                    bitcnt_d = 4'd1;
                    timer_d  = '0;
                    state_d  = S_DATA;
                end else if (timer_q == N_START - 24'd1) begin
                    error_go = 1'b1;
                end
            end

            S_DATA: begin
                if (fall_q) begin
                    timer_d = '0;
                    if (bitcnt_q == 4'd8) begin
                        dat_oe_d = ~parity_q;
                        state_d  = S_PARITY;
                    end else begin
                        dat_oe_d = ~data_q[bitcnt_q[2:0]];
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end else if (bit_tc) begin
                    error_go = 1'b1;
                end
            end

            S_PARITY: begin
                if (fall_q) begin
                    timer_d  = '0;
                    dat_oe_d = 1'b0;
                    state_d  = S_STOP;
                end else if (bit_tc) begin
                    error_go = 1'b1;
                end
            end

            S_STOP: begin
                if (fall_q) begin
                    timer_d = '0;
                    if (!dat_line) begin
                        state_d = S_RELEASE;
                    end else begin
                        error_go = 1'b1;
                    end
                end else if (bit_tc) begin
                    error_go = 1'b1;
                end
            end

            S_RELEASE: begin
                if (clk_line && dat_line) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (fall_q) begin
                    timer_d = '0;
                end else if (bit_tc) begin
                    error_go = 1'b1;
                end
            end

            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        if (error_go) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            error_d  = 1'b1;
            state_d  = S_IDLE;
        end
    end

endmodule
